// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared encodings and GF(2^8) helpers for the AES decipher round engine
package aes_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } dec_state_e;

  // Which transformation is written into the state register this cycle
  typedef enum logic [2:0] {
    UPD_NONE  = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } upd_type_e;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;
  localparam logic       KEYLEN_128    = 1'b0;
  localparam logic       KEYLEN_256    = 1'b1;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] x);
    return gm2(gm2(gm2(x))) ^ x;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] x);
    return gm2(gm2(gm2(x))) ^ gm2(x) ^ x;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] x);
    return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ x;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] x);
    return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ gm2(x);
  endfunction

  // Column c is word c (bits 127-32c downto 96-32c); row r is byte r within it
  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] st);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127 - 32*c -: 8];
      a1 = st[119 - 32*c -: 8];
      a2 = st[111 - 32*c -: 8];
      a3 = st[103 - 32*c -: 8];
      res[127 - 32*c -: 8] = gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3);
      res[119 - 32*c -: 8] = gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3);
      res[111 - 32*c -: 8] = gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3);
      res[103 - 32*c -: 8] = gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3);
    end
    return res;
  endfunction

  // Row r rotates right by r columns
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - four parallel AES inverse S-box lookups on one 32-bit word
module aes_inv_sbox (
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign new_sword = {INV_SBOX[sword[31:24]], INV_SBOX[sword[23:16]],
                      INV_SBOX[sword[15:8]],  INV_SBOX[sword[7:0]]};

endmodule

// File: rtl/aes_decipher_round_engine.sv
// rtl/aes_decipher_round_engine.sv - iterative AES-128/256 decryption datapath with external key memory
module aes_decipher_round_engine
  import aes_dec_pkg::*;
#(
  parameter int SBOX_LANES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int         SBOX_CYCLES = (SBOX_LANES > 0) ? (4 / SBOX_LANES) : 1;
  localparam logic [1:0] CTR_LAST    = 2'(SBOX_CYCLES - 1);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("aes_decipher_round_engine: SBOX_LANES must be 1, 2 or 4");
  end

  dec_state_e   state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr_q, nr_d;
  logic [1:0]   ctr_q, ctr_d;
  logic         ready_q, ready_d;
  upd_type_e    upd;

  logic [1:0]   lane_idx [SBOX_LANES];
  logic [31:0]  lane_in  [SBOX_LANES];
  logic [31:0]  lane_out [SBOX_LANES];

  // Lane i handles word ctr*SBOX_LANES+i; word 0 sits in the top 32 bits
  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
    assign lane_idx[i] = 2'((int'(ctr_q) * SBOX_LANES + i) % 4);
    assign lane_in[i]  = block_q[127 - 32*lane_idx[i] -: 32];

    aes_inv_sbox u_inv_sbox (
      .sword     (lane_in[i]),
      .new_sword (lane_out[i])
    );
  end

  // Sequencing: state, round index, word counter, latched round count and ready flag
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    ctr_d   = ctr_q;
    ready_d = ready_q;
    upd     = UPD_NONE;
    case (state_q)
      ST_IDLE: begin
        if (next) begin
          nr_d    = (keylen == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
          round_d = (keylen == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
          ready_d = 1'b0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        // Address the last round key from the latched count, not from keylen
        round_d = nr_q;
        upd     = UPD_INIT;
        ctr_d   = 2'd0;
        state_d = ST_SBOX;
      end
      ST_SBOX: begin
        upd   = UPD_SBOX;
        ctr_d = ctr_q + 2'd1;
        if (ctr_q == CTR_LAST) begin
          ctr_d   = 2'd0;
          round_d = round_q - 4'd1;
          state_d = ST_MAIN;
        end
      end
      ST_MAIN: begin
        ctr_d = 2'd0;
        if (round_q != 4'd0) begin
          upd     = UPD_MAIN;
          state_d = ST_SBOX;
        end else begin
          upd     = UPD_FINAL;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-register update selected by the sequencer; untouched words keep their value
  always_comb begin
    block_d = block_q;
    case (upd)
      UPD_INIT:  block_d = inv_shiftrows(block ^ round_key);
      UPD_SBOX: begin
        for (int i = 0; i < SBOX_LANES; i++) begin
          block_d[127 - 32*lane_idx[i] -: 32] = lane_out[i];
        end
      end
      UPD_MAIN:  block_d = inv_shiftrows(inv_mixcolumns(block_q ^ round_key));
      UPD_FINAL: block_d = block_q ^ round_key;
      default:   block_d = block_q;
    endcase
  end

  // Registers; reset aborts any operation and leaves the engine idle and ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      block_q <= '0;
      round_q <= 4'd0;
      nr_q    <= AES128_ROUNDS;
      ctr_q   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      ctr_q   <= ctr_d;
      ready_q <= ready_d;
    end
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule
